// File: rtl/dm_ndmreset_ctrl.sv
// Debug-module ndmreset sequencer: turns the DM's ndmreset/dmactive into a
// minimum-width, glitch-free active-low system reset and reports completion.
module dm_ndmreset_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic testmode_i,
  input  logic ndmreset_i,
  input  logic dmactive_i,
  input  logic ackhavereset_i,
  output logic sys_rst_no,
  output logic ndmreset_busy_o,
  output logic reset_done_o,
  output logic havereset_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_REL = 2'd2,
    SETTLE   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sys_rst_nq, sys_rst_nd;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             havereset_q, havereset_d;
  logic             req_c;

  assign req_c = ndmreset_i & dmactive_i;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c && !testmode_i) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end
      end
      ASSERT: begin
        if (testmode_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          // Request already gone: skip the release wait so low time is exactly HOLD_CYCLES
          state_d = req_c ? WAIT_REL : SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (testmode_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!req_c) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (testmode_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    sys_rst_nd  = (state_d == IDLE) || (state_d == SETTLE);
    busy_d      = (state_d != IDLE);
    // Completion wins over a coincident acknowledge
    havereset_d = done_d ? 1'b1 : (ackhavereset_i ? 1'b0 : havereset_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sys_rst_nq  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      havereset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_rst_nq  <= sys_rst_nd;
      busy_q      <= busy_d;
      done_q      <= done_d;
      havereset_q <= havereset_d;
    end
  end

  assign sys_rst_no      = sys_rst_nq;
  assign ndmreset_busy_o = busy_q;
  assign reset_done_o    = done_q;
  assign havereset_o     = havereset_q;

endmodule

// File: tb/tb_dm_ndmreset_ctrl.sv
// Scoreboard bench for dm_ndmreset_ctrl: per-cycle expected {sys_rst_n, busy,
// done, havereset} vectors are derived from the request timeline.
module tb_dm_ndmreset_ctrl;

  localparam int HOLD   = 16;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst_n, testmode, ndmreset, dmactive, ack;
  logic sys_rst_n, busy, done, hr;

  logic [3:0] exp_q[$];
  logic [3:0] obs, expv;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_ndmreset_ctrl #(
    .HOLD_CYCLES  (HOLD),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .testmode_i     (testmode),
    .ndmreset_i     (ndmreset),
    .dmactive_i     (dmactive),
    .ackhavereset_i (ack),
    .sys_rst_no     (sys_rst_n),
    .ndmreset_busy_o(busy),
    .reset_done_o   (done),
    .havereset_o    (hr)
  );

  // Expected outputs after edge k for a sequence entered at edge s with reset low for 'low' cycles
  function automatic logic [3:0] seq_exp(input int k, input int s, input int low, input logic hr0);
    logic sys_e, busy_e, done_e, hr_e;
    sys_e  = !(k >= s && k < s + low);
    busy_e = (k >= s && k < s + low + SETTLE);
    done_e = (k == s + low + SETTLE);
    hr_e   = (k >= s + low + SETTLE) ? 1'b1 : hr0;
    return {sys_e, busy_e, done_e, hr_e};
  endfunction

  task automatic drive(input logic r, input logic tm, input logic req, input logic act, input logic a);
    @(negedge clk);
    rst_n    = r;
    testmode = tm;
    ndmreset = req;
    dmactive = act;
    ack      = a;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 6; k++) begin
      drive(k >= 2, 1'b0, 1'b0, 1'b0, k == 3);
      exp_q.push_back({1'b1, 1'b0, 1'b0, logic'(k < 3)});
      @(posedge clk); #1;
      obs = {sys_rst_n, busy, done, hr}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL reset k=%0d got=%b exp=%b", k, obs, expv);
      end
    end
  endtask

  task automatic test_short_request();
    for (int k = 0; k < 23; k++) begin
      drive(1'b1, 1'b0, k <= 2, 1'b1, 1'b0);
      exp_q.push_back(seq_exp(k, 0, HOLD, 1'b0));
      @(posedge clk); #1;
      obs = {sys_rst_n, busy, done, hr}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL short_request k=%0d got=%b exp=%b", k, obs, expv);
      end
    end
  endtask

  task automatic test_long_request();
    for (int k = 0; k < 47; k++) begin
      drive(1'b1, 1'b0, k <= 39, 1'b1, 1'b0);
      exp_q.push_back(seq_exp(k, 0, 40, 1'b1));
      @(posedge clk); #1;
      obs = {sys_rst_n, busy, done, hr}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL long_request k=%0d got=%b exp=%b", k, obs, expv);
      end
    end
  endtask

  task automatic test_gating();
    // dmactive low (ack at k=0 clears havereset; ack at k=10 hits an already-clear flag)
    for (int k = 0; k < 30; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, k == 0 || k == 10);
      exp_q.push_back(4'b1000);
      @(posedge clk); #1;
      obs = {sys_rst_n, busy, done, hr}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL gate_dmactive k=%0d got=%b exp=%b", k, obs, expv);
      end
    end
    for (int k = 0; k < 30; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      exp_q.push_back(4'b1000);
      @(posedge clk); #1;
      obs = {sys_rst_n, busy, done, hr}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL gate_testmode k=%0d got=%b exp=%b", k, obs, expv);
      end
    end
    // testmode raised in cycle 5 of ASSERT aborts the sequence
    for (int k = 0; k < 30; k++) begin
      drive(1'b1, k == 5, k <= 5, 1'b1, 1'b0);
      exp_q.push_back((k < 5) ? 4'b0100 : 4'b1000);
      @(posedge clk); #1;
      obs = {sys_rst_n, busy, done, hr}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL testmode_abort k=%0d got=%b exp=%b", k, obs, expv);
      end
    end
  endtask

  task automatic test_ack_collision();
    logic [3:0] e;
    for (int k = 0; k < 24; k++) begin
      drive(1'b1, 1'b0, k <= 2, 1'b1, k == 20 || k == 22);
      e = seq_exp(k, 0, HOLD, 1'b0);
      if (k >= 22) e[0] = 1'b0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      obs = {sys_rst_n, busy, done, hr}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL ack_collision k=%0d got=%b exp=%b", k, obs, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 44; k++) begin
      drive(1'b1, 1'b0, (k <= 2) || (k >= 17 && k <= 21), 1'b1, 1'b0);
      exp_q.push_back((k < 21) ? seq_exp(k, 0, HOLD, 1'b0) : seq_exp(k, 21, HOLD, 1'b1));
      @(posedge clk); #1;
      obs = {sys_rst_n, busy, done, hr}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL back_to_back k=%0d got=%b exp=%b", k, obs, expv);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 30; k++) begin
      drive(!(k == 20 || k == 21), 1'b0, k < 20, 1'b1, k == 0);
      exp_q.push_back((k < 20) ? 4'b0100 : 4'b1001);
      @(posedge clk); #1;
      obs = {sys_rst_n, busy, done, hr}; expv = exp_q.pop_front(); checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL mid_reset k=%0d got=%b exp=%b", k, obs, expv);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    testmode = 1'b0;
    ndmreset = 1'b0;
    dmactive = 1'b0;
    ack      = 1'b0;
    test_reset();
    test_short_request();
    test_long_request();
    test_gating();
    test_ack_collision();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
